// File: rtl/seq_step_pkg.sv
// Shared types for the step sequencer.
// State enum, step-table entry and index width helper.
package seq_step_pkg;

  // Widths of step_entry_t; the engine's NUM_CH/DATA_W must equal these.
  localparam int SEQ_NUM_CH = 4;
  localparam int SEQ_DATA_W = 8;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef struct packed {
    logic [SEQ_NUM_CH-1:0]                 mask;
    logic [SEQ_NUM_CH-1:0][SEQ_DATA_W-1:0] data;
    logic                                  last;
  } step_entry_t;

endpackage

// File: rtl/seq_step_table.sv
// Step table: sync-reset register file, one write port,
// one combinational read port (raddr -> rentry).
module seq_step_table
  import seq_step_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int STEP_W    = idx_w(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [STEP_W-1:0] waddr,
  input  step_entry_t       wentry,
  input  logic [STEP_W-1:0] raddr,
  output step_entry_t       rentry
);

  step_entry_t tbl [NUM_STEPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++)
        tbl[i] <= '0;
    end else if (we) begin
      tbl[waddr] <= wentry;
    end
  end

  assign rentry = tbl[raddr];

endmodule

// File: rtl/seq_step_engine.sv
// Programmable step sequencer: FSM, step index, channel regs.
// Ports: cfg_* table write, start/stall/loop_en control,
// busy/done/cfg_err status, step_idx, ch_out channels.
module seq_step_engine
  import seq_step_pkg::*;
#(
  parameter int NUM_CH     = SEQ_NUM_CH,
  parameter int DATA_W     = SEQ_DATA_W,
  parameter int NUM_STEPS  = 8,
  parameter int STEP_W     = idx_w(NUM_STEPS),
  parameter int AUTO_START = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [STEP_W-1:0]        cfg_addr,
  input  logic [NUM_CH-1:0]        cfg_mask,
  input  logic [NUM_CH*DATA_W-1:0] cfg_data,
  input  logic                     cfg_last,
  input  logic                     start,
  input  logic                     loop_en,
  input  logic                     stall,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  output logic [STEP_W-1:0]        step_idx,
  output logic [NUM_CH*DATA_W-1:0] ch_out
);

  state_t      state;
  logic        auto_pend;
  step_entry_t wentry;
  step_entry_t cur;
  logic        is_last;

  assign wentry.mask = cfg_mask;
  assign wentry.data = cfg_data;
  assign wentry.last = cfg_last;

  seq_step_table #(
    .NUM_STEPS (NUM_STEPS),
    .STEP_W    (STEP_W)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .we     (cfg_we && state == IDLE),
    .waddr  (cfg_addr),
    .wentry (wentry),
    .raddr  (step_idx),
    .rentry (cur)
  );

  // Last table slot ends the pass even if not marked.
  assign is_last = cur.last ||
                   (step_idx == STEP_W'(NUM_STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      auto_pend <= 1'(AUTO_START);
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      step_idx  <= '0;
      ch_out    <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start || auto_pend) begin
            state     <= RUN;
            busy      <= 1'b1;
            auto_pend <= 1'b0;
            step_idx  <= '0;
          end
        end
        RUN: begin
          cfg_err <= cfg_we;
          if (!stall) begin
            for (int i = 0; i < NUM_CH; i++)
              if (cur.mask[i])
                ch_out[i*DATA_W +: DATA_W] <= cur.data[i];
            if (is_last) begin
              done     <= 1'b1;
              step_idx <= '0;
              if (!loop_en) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              step_idx <= step_idx + STEP_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_step_engine.sv
// Directed bench for seq_step_engine.
// dut: AUTO_START=1, dut2: AUTO_START=0.
module tb_seq_step_engine;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [3:0]  cfg_mask;
  logic [31:0] cfg_data;
  logic        cfg_last;
  logic        start, start2, loop_en, stall;

  logic        busy, done, cfg_err;
  logic [2:0]  step_idx;
  logic [31:0] ch_out;
  logic        busy2, done2, cfg_err2;
  logic [2:0]  step_idx2;
  logic [31:0] ch_out2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_step_engine dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mask(cfg_mask), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .start(start), .loop_en(loop_en), .stall(stall),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .step_idx(step_idx), .ch_out(ch_out)
  );

  seq_step_engine #(.AUTO_START(0)) dut2 (
    .clk(clk), .rst(rst2), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mask(cfg_mask), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .start(start2), .loop_en(loop_en), .stall(stall),
    .busy(busy2), .done(done2), .cfg_err(cfg_err2),
    .step_idx(step_idx2), .ch_out(ch_out2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] a, input logic [3:0] m,
                     input logic [31:0] d, input logic l);
    cfg_we = 1'b1; cfg_addr = a; cfg_mask = m;
    cfg_data = d; cfg_last = l;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1;
    tick; tick;
    checks++;
    if (ch_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0 ||
        cfg_err !== 1'b0 || step_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_state ch=%h busy=%b done=%b err=%b idx=%0d want all 0",
               ch_out, busy, done, cfg_err, step_idx);
    end
    checks++;
    if (ch_out2 !== 32'h0 || busy2 !== 1'b0 || step_idx2 !== 3'd0) begin
      errors++;
      $display("FAIL reset_state2 ch=%h busy=%b idx=%0d want 0",
               ch_out2, busy2, step_idx2);
    end
    rst = 1'b0; rst2 = 1'b0;
  endtask

  // Auto-start on an empty table: all 8 slots run, then done.
  task automatic test_auto_full;
    tick;
    checks++;
    if (busy !== 1'b1 || step_idx !== 3'd0) begin
      errors++;
      $display("FAIL auto_start busy=%b idx=%0d want 1/0", busy, step_idx);
    end
    for (int k = 1; k <= 7; k++) begin
      tick;
      checks++;
      if (step_idx !== 3'(k) || busy !== 1'b1 ||
          done !== 1'b0 || ch_out !== 32'h0) begin
        errors++;
        $display("FAIL full_step%0d idx=%0d busy=%b done=%b ch=%h want %0d/1/0/0",
                 k, step_idx, busy, done, ch_out, k);
      end
      checks++;
      if (busy2 !== 1'b0) begin
        errors++;
        $display("FAIL noauto_idle%0d busy2=%b want 0", k, busy2);
      end
    end
    tick;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || step_idx !== 3'd0) begin
      errors++;
      $display("FAIL full_done done=%b busy=%b idx=%0d want 1/0/0",
               done, busy, step_idx);
    end
    tick;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL full_done_pulse done=%b want 0", done);
    end
  endtask

  task automatic test_no_auto;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    checks++;
    if (busy2 !== 1'b1 || step_idx2 !== 3'd0) begin
      errors++;
      $display("FAIL noauto_start busy2=%b idx2=%0d want 1/0", busy2, step_idx2);
    end
    repeat (8) tick;
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL noauto_done done2=%b busy2=%b busy=%b want 1/0/0",
               done2, busy2, busy);
    end
  endtask

  task automatic test_basic;
    cfg(3'd0, 4'b0001, 32'h0000_0001, 1'b0);
    cfg(3'd1, 4'b0010, 32'h0000_0200, 1'b0);
    cfg(3'd2, 4'b1100, 32'h0403_0000, 1'b1);
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ch_out !== 32'h0) begin
      errors++;
      $display("FAIL basic_enter busy=%b ch=%h want 1/0", busy, ch_out);
    end
    tick;
    checks++;
    if (ch_out !== 32'h0000_0001 || step_idx !== 3'd1) begin
      errors++;
      $display("FAIL basic_s0 ch=%h idx=%0d want 00000001/1", ch_out, step_idx);
    end
    tick;
    checks++;
    if (ch_out !== 32'h0000_0201 || step_idx !== 3'd2) begin
      errors++;
      $display("FAIL basic_s1 ch=%h idx=%0d want 00000201/2", ch_out, step_idx);
    end
    tick;
    checks++;
    if (ch_out !== 32'h0403_0201 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_s2 ch=%h done=%b busy=%b want 04030201/1/0",
               ch_out, done, busy);
    end
    tick;
    checks++;
    if (done !== 1'b0 || ch_out !== 32'h0403_0201) begin
      errors++;
      $display("FAIL basic_hold done=%b ch=%h want 0/04030201", done, ch_out);
    end
  endtask

  task automatic test_stall;
    cfg(3'd1, 4'b0010, 32'h0000_2200, 1'b0);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (step_idx !== 3'd1 || ch_out !== 32'h0403_0201) begin
        errors++;
        $display("FAIL stall_hold%0d idx=%0d ch=%h want 1/04030201",
                 k, step_idx, ch_out);
      end
    end
    stall = 1'b0;
    tick;
    checks++;
    if (ch_out !== 32'h0403_2201 || step_idx !== 3'd2) begin
      errors++;
      $display("FAIL stall_resume ch=%h idx=%0d want 04032201/2", ch_out, step_idx);
    end
    tick;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_done done=%b busy=%b want 1/0", done, busy);
    end
  endtask

  task automatic test_loop_wait;
    logic [31:0] exp_ch [4];
    exp_ch[0] = 32'h0403_2211;
    exp_ch[1] = 32'h0403_1211;
    exp_ch[2] = 32'h0403_1211;
    exp_ch[3] = 32'h1413_1211;
    cfg(3'd0, 4'b0001, 32'h0000_0011, 1'b0);
    cfg(3'd1, 4'b0010, 32'h0000_1200, 1'b0);
    cfg(3'd2, 4'b0000, 32'hdead_beef, 1'b0);
    cfg(3'd3, 4'b1100, 32'h1413_0000, 1'b1);
    loop_en = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (p == 2) loop_en = 1'b0;
      for (int s = 0; s < 4; s++) begin
        tick;
        if (p == 0) begin
          checks++;
          if (ch_out !== exp_ch[s]) begin
            errors++;
            $display("FAIL loop_ch_s%0d ch=%h want %h", s, ch_out, exp_ch[s]);
          end
        end
        checks++;
        if (done !== (s == 3) || step_idx !== 3'((s + 1) % 4) ||
            busy !== !(p == 2 && s == 3)) begin
          errors++;
          $display("FAIL loop_p%0d_s%0d done=%b idx=%0d busy=%b want %b/%0d/%b",
                   p, s, done, step_idx, busy, (s == 3), (s + 1) % 4,
                   !(p == 2 && s == 3));
        end
      end
    end
  endtask

  task automatic test_cfg_busy;
    cfg(3'd1, 4'b0010, 32'h0000_0200, 1'b0);
    start = 1'b1;
    tick;
    start = 1'b0;
    cfg(3'd1, 4'b0010, 32'h0000_7700, 1'b0);
    checks++;
    if (cfg_err !== 1'b1 || ch_out !== 32'h1413_1211) begin
      errors++;
      $display("FAIL cfgbusy_err err=%b ch=%h want 1/14131211", cfg_err, ch_out);
    end
    tick;
    checks++;
    if (cfg_err !== 1'b0 || ch_out !== 32'h1413_0211) begin
      errors++;
      $display("FAIL cfgbusy_s1 err=%b ch=%h want 0/14130211", cfg_err, ch_out);
    end
    tick; tick;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ch_out !== 32'h1413_0211) begin
      errors++;
      $display("FAIL cfgbusy_done done=%b busy=%b ch=%h want 1/0/14130211",
               done, busy, ch_out);
    end
  endtask

  task automatic test_cfg_start;
    start = 1'b1;
    cfg(3'd0, 4'b0001, 32'h0000_0055, 1'b0);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfgstart_enter busy=%b err=%b want 1/0", busy, cfg_err);
    end
    tick;
    checks++;
    if (ch_out !== 32'h1413_0255) begin
      errors++;
      $display("FAIL cfgstart_s0 ch=%h want 14130255", ch_out);
    end
    tick; tick; tick;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cfgstart_done done=%b busy=%b want 1/0", done, busy);
    end
  endtask

  task automatic test_reset_midrun;
    cfg(3'd0, 4'b0001, 32'h0000_0001, 1'b0);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    checks++;
    if (ch_out !== 32'h1413_0201) begin
      errors++;
      $display("FAIL midrun_pre ch=%h want 14130201", ch_out);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (ch_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0 ||
        cfg_err !== 1'b0 || step_idx !== 3'd0) begin
      errors++;
      $display("FAIL midrun_rst ch=%h busy=%b done=%b err=%b idx=%0d want 0",
               ch_out, busy, done, cfg_err, step_idx);
    end
    // Auto-restart over the cleared table must leave channels at 0.
    tick;
    for (int k = 1; k <= 8; k++) begin
      tick;
      checks++;
      if (ch_out !== 32'h0 || done !== (k == 8)) begin
        errors++;
        $display("FAIL midrun_cleared%0d ch=%h done=%b want 0/%b",
                 k, ch_out, done, (k == 8));
      end
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_mask = '0;
    cfg_data = '0; cfg_last = 1'b0;
    start = 1'b0; start2 = 1'b0;
    loop_en = 1'b0; stall = 1'b0;
    test_reset;
    test_auto_full;
    test_no_auto;
    test_basic;
    test_stall;
    test_loop_wait;
    test_cfg_busy;
    test_cfg_start;
    test_reset_midrun;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
